put_arb: RTL and testbench
==========================

PUT_ARB -- requirements
Module: put_arb

Interface
REQ-001 Parameter N, default 4, number of requesters, legal range 2..8.
REQ-002 Parameter DW, default 8, payload width per requester.
REQ-003 Parameter TMO, default 1023, WAIT-state cycle limit before stall flag sets, legal range 1..65535.
REQ-004 wclk  in  1  sole clock; all state updates on its rising edge.
REQ-005 wrst_n  in  1  reset; asynchronous, active-low.
REQ-006 req  in  N  per-requester request level; held high until matching gnt bit.
REQ-007 req_data  in  N*DW  packed payloads; requester i owns bits [i*DW +: DW], stable while req[i] high.
REQ-008 gnt  out  N  one-hot, one-cycle accept pulse to the winning requester.
REQ-009 wrdy  in  1  mailbox slot free, from single-entry toggle-pointer write control (pointers differ = full).
REQ-010 wput  out  1  one-cycle write strobe to the write control.
REQ-011 wdata  out  DW+clog2(N)  {source id, payload} presented to the mailbox.
REQ-012 stall  out  1  sticky flag: mailbox not drained within TMO cycles.

Function
REQ-013 FSM SHALL have states IDLE, PUT and WAIT.
REQ-014 IDLE: if wrdy=1 and |req, wdata SHALL load {winner id, winner payload} at the clock edge, and the FSM SHALL move to PUT.
REQ-015 IDLE with wrdy=0 or req=0 SHALL hold IDLE, with no change to wdata.
REQ-016 PUT: wput=1 and gnt[winner]=1 SHALL be asserted in the same cycle, and only when wrdy=1.
REQ-017 PUT with wrdy=1: the FSM SHALL move to WAIT and update the last-winner register.
REQ-018 PUT with wrdy=0: the FSM SHALL hold PUT, with wput=0, gnt=0 and wdata unchanged.
REQ-019 WAIT: the FSM SHALL stay in WAIT while wrdy=0 and return to IDLE on the first cycle wrdy=1.
REQ-020 Winner selection SHALL be round-robin: the first asserted req at index last+1, last+2, ... modulo N.
REQ-021 The last-winner register SHALL update only on an accepted put.
REQ-022 Minimum latency SHALL be one cycle from req sampled in IDLE to wput/gnt.
REQ-023 Minimum put-to-put spacing SHALL be 3 cycles.
REQ-024 Requests arriving, or dropping, while in PUT or WAIT SHALL NOT alter the latched winner or wdata.
REQ-025 A requester that deasserts req before its gnt forfeits; arbitration SHALL ignore it from the next IDLE evaluation.
REQ-026 At most one gnt bit SHALL be high in any cycle, and gnt SHALL only be high while wput=1.
REQ-027 WAIT cycle counter: reset to 0 on WAIT entry, saturating.
REQ-028 stall SHALL set when the WAIT cycle counter reaches TMO.
REQ-029 stall SHALL clear only by reset.
REQ-030 wput SHALL never assert in two consecutive cycles.

Reset
REQ-031 While wrst_n=0, the FSM SHALL be in IDLE with wput=0, gnt=0, wdata=0, stall=0, WAIT cycle counter=0 and last-winner=N-1, so requester 0 has first priority.
REQ-032 Reset asserted mid-PUT or mid-WAIT SHALL force all outputs to their reset values immediately, without waiting for wclk.
REQ-033 Deassertion of wrst_n SHALL take effect at the next wclk edge, and no put SHALL issue in the first post-reset cycle.

Verification
REQ-034 N=4, DW=8, wrdy=1, req=0001, req_data[0]=0x5A -> cycle+1 wput=1, gnt=0001, wdata={2'd0,0x5A}.
REQ-035 req=1111 held, wrdy returns 1 two cycles after each put -> grant order 0,1,2,3,0, with puts 3 cycles apart.
REQ-036 wrdy=0 at req=0100 -> no wput until wrdy=1, then wput one cycle later with gnt=0100.
REQ-037 After a put, wrdy held 0 for TMO+5 cycles -> stall=1 at WAIT cycle TMO and remains 1 after wrdy=1.
REQ-038 wrst_n pulsed low during WAIT, with req=0010 pending -> outputs zero asynchronously; after release, gnt=0010 is the first grant; stall=0.

Source files
------------

// File: rtl/put_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : put_arb_if
//  Description : Request/grant and mailbox-write bundle for put_arb.
//                master = arbiter side, slave = requesters + write control.
//  Revision    : 1.0  initial release
// ============================================================================
interface put_arb_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      gnt;
    logic              wrdy;
    logic              wput;
    logic [DW+IW-1:0]  wdata;
    logic              stall;

    modport master (
        input  req, req_data, wrdy,
        output gnt, wput, wdata, stall
    );

    modport slave (
        output req, req_data, wrdy,
        input  gnt, wput, wdata, stall
    );
endinterface
`default_nettype wire

// File: rtl/put_arb.sv
`default_nettype none
// ============================================================================
//  Module      : put_arb
//  Description : Round-robin arbiter feeding a single-entry mailbox. Latches
//                {winner id, payload} in IDLE, issues one put/grant pulse in
//                PUT once the slot is free, then waits in WAIT for the slot
//                to drain, flagging a sticky stall after TMO cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module put_arb #(
    parameter int N   = 4,
    parameter int DW  = 8,
    parameter int TMO = 1023
) (
    input  wire logic   wclk,
    input  wire logic   wrst_n,
    put_arb_if.master   bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = 16;
    localparam logic [CW-1:0] TMO_C  = CW'(TMO);
    localparam logic [IW-1:0] LAST_R = IW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PUT  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    last_q,  last_d;
    logic [IW-1:0]    win_q,   win_d;
    logic [DW+IW-1:0] wdata_q, wdata_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             stall_q, stall_d;

    logic             rr_found;
    logic [IW-1:0]    rr_id;
    logic [DW-1:0]    rr_pay;
    int               rr_idx;
    logic             put_fire;

    // Round-robin search: first asserted request after the last winner.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = '0;
        rr_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            rr_idx = int'(last_q) + k;
            if (rr_idx >= N) rr_idx = rr_idx - N;
            if (!rr_found && bus.req[rr_idx[IW-1:0]]) begin
                rr_found = 1'b1;
                rr_id    = rr_idx[IW-1:0];
            end
        end
    end

    // Payload mux for the selected requester.
    always_comb begin
        rr_pay = '0;
        for (int i = 0; i < N; i++) begin
            if (rr_id == IW'(i)) rr_pay = bus.req_data[i*DW +: DW];
        end
    end

    // A put is accepted only in PUT while the mailbox slot is free.
    assign put_fire  = (state_q == PUT) && bus.wrdy;
    assign bus.wput  = put_fire;
    assign bus.gnt   = put_fire ? (N'(1) << win_q) : '0;
    assign bus.wdata = wdata_q;
    assign bus.stall = stall_q;

    // Next-state logic for the FSM, winner latch, wait counter and stall flag.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        case (state_q)
            IDLE: begin
                // Winner and payload are frozen here; later req changes are ignored.
                if (bus.wrdy && rr_found) begin
                    win_d   = rr_id;
                    wdata_d = {rr_id, rr_pay};
                    state_d = PUT;
                end
            end
            PUT: begin
                if (bus.wrdy) begin
                    last_d  = win_q;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.wrdy) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
                    // Flag is visible in the same cycle the counter equals TMO.
                    if (cnt_d == TMO_C) stall_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; async reset clears outputs without waiting for wclk.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            last_q  <= LAST_R;
            win_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_put_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_put_arb
//  Description : Directed self-checking bench for put_arb (N=4, DW=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_put_arb;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic wclk = 1'b0;
    logic wrst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] bytes_c [4] = '{8'h5A, 8'hB1, 8'hC2, 8'hD3};

    put_arb_if #(.N(N), .DW(DW)) bus ();

    put_arb #(.N(N), .DW(DW), .TMO(TMO)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    always #5 wclk = ~wclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected mailbox word for requester id.
    function automatic logic [31:0] exp_word(input int id);
        return 32'((id << 8) | int'(bytes_c[id]));
    endfunction

    task automatic do_reset();
        @(negedge wclk);
        wrst_n   = 1'b0;
        bus.req  = '0;
        bus.wrdy = 1'b0;
        @(negedge wclk);
        wrst_n   = 1'b1;
    endtask

    initial begin : main
        int order [5] = '{0, 1, 2, 3, 0};
        int k;
        int prev;

        wrst_n       = 1'b0;
        bus.req      = '0;
        bus.req_data = {bytes_c[3], bytes_c[2], bytes_c[1], bytes_c[0]};
        bus.wrdy     = 1'b0;

        // ---------------- reset state ----------------
        @(negedge wclk);
        bus.req  = 4'b1111;
        bus.wrdy = 1'b1;
        @(negedge wclk); #1;
        check_val("rst_wput",  32'(bus.wput),  0);
        check_val("rst_gnt",   32'(bus.gnt),   0);
        check_val("rst_wdata", 32'(bus.wdata), 0);
        check_val("rst_stall", 32'(bus.stall), 0);

        // ---------------- single request, minimum latency ----------------
        bus.req = '0;
        wrst_n  = 1'b1;
        @(negedge wclk);
        bus.req = 4'b0001;
        #1;
        check_val("t1_idle_wput", 32'(bus.wput), 0);
        @(negedge wclk); #1;
        check_val("t1_wput",  32'(bus.wput),  1);
        check_val("t1_gnt",   32'(bus.gnt),   32'h1);
        check_val("t1_wdata", 32'(bus.wdata), 32'h05A);
        bus.req = '0;
        @(negedge wclk); #1;
        check_val("t1_wait_wput", 32'(bus.wput), 0);
        check_val("t1_wdata_hold", 32'(bus.wdata), 32'h05A);

        // ---------------- round robin, all requesting ----------------
        do_reset();
        bus.req  = 4'b1111;
        bus.wrdy = 1'b1;
        k    = 0;
        prev = -10;
        for (int c = 1; c <= 15; c++) begin
            @(negedge wclk); #1;
            if (bus.wput) begin
                if (k < 5) begin
                    check_val("t2_gnt",   32'(bus.gnt),   32'(1) << order[k]);
                    check_val("t2_wdata", 32'(bus.wdata), exp_word(order[k]));
                    if (k > 0) check_val("t2_spacing", 32'(c - prev), 3);
                end
                prev = c;
                k++;
            end else begin
                check_val("t2_gnt_idle", 32'(bus.gnt), 0);
            end
        end
        check_val("t2_nputs", 32'(k), 5);

        // ---------------- slot busy, then released ----------------
        do_reset();
        bus.req  = 4'b0100;
        bus.wrdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge wclk); #1;
            check_val("t3_blocked", 32'(bus.wput), 0);
        end
        @(negedge wclk);
        bus.wrdy = 1'b1;
        #1;
        check_val("t3_same_cycle", 32'(bus.wput), 0);
        @(negedge wclk); #1;
        check_val("t3_wput",  32'(bus.wput),  1);
        check_val("t3_gnt",   32'(bus.gnt),   32'h4);
        check_val("t3_wdata", 32'(bus.wdata), exp_word(2));
        bus.req = '0;

        // ---------------- mailbox not drained: stall ----------------
        @(negedge wclk);
        bus.wrdy = 1'b0;
        #1;
        check_val("t4_stall_w0", 32'(bus.stall), 0);
        for (int j = 1; j <= TMO + 4; j++) begin
            @(negedge wclk); #1;
            if (j == TMO - 1) check_val("t4_stall_pre", 32'(bus.stall), 0);
            if (j == TMO)     check_val("t4_stall_at",  32'(bus.stall), 1);
            if (j == TMO + 4) check_val("t4_stall_late", 32'(bus.stall), 1);
        end
        bus.wrdy = 1'b1;
        @(negedge wclk); #1;
        check_val("t4_stall_sticky", 32'(bus.stall), 1);
        check_val("t4_idle_wput",    32'(bus.wput),  0);

        // ---------------- PUT hold, late arrivals, async reset ----------------
        do_reset();
        check_val("t5_stall_cleared", 32'(bus.stall), 0);
        bus.req  = 4'b0001;
        bus.wrdy = 1'b1;
        @(negedge wclk);
        bus.wrdy = 1'b0;
        bus.req  = 4'b0011;
        #1;
        check_val("t5_hold_wput", 32'(bus.wput), 0);
        check_val("t5_hold_gnt",  32'(bus.gnt),  0);
        @(negedge wclk);
        bus.wrdy = 1'b1;
        #1;
        check_val("t5_gnt",   32'(bus.gnt),   32'h1);
        check_val("t5_wdata", 32'(bus.wdata), exp_word(0));
        bus.req = 4'b0010;
        @(negedge wclk);
        bus.wrdy = 1'b0;
        @(negedge wclk);
        #1;
        wrst_n = 1'b0;
        #1;
        check_val("t5_async_wdata", 32'(bus.wdata), 0);
        check_val("t5_async_wput",  32'(bus.wput),  0);
        check_val("t5_async_gnt",   32'(bus.gnt),   0);
        check_val("t5_async_stall", 32'(bus.stall), 0);
        @(negedge wclk);
        wrst_n   = 1'b1;
        bus.wrdy = 1'b1;
        #1;
        check_val("t5_post_rst_wput", 32'(bus.wput), 0);
        @(negedge wclk); #1;
        check_val("t5_first_gnt", 32'(bus.gnt),   32'h2);
        check_val("t5_first_wd",  32'(bus.wdata), exp_word(1));
        check_val("t5_stall",     32'(bus.stall), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
